fifo_serial_reader: RTL and testbench
=====================================

# fifo_serial_reader

Read-side companion of the team's FIFO: pops words from the FIFO whenever it is non-empty and transmits each one as a framed serial stream on a single line. The framing is 1 start bit (0), WIDTH data bits LSB-first, and 1 stop bit (1). It sits between the FIFO's O/Empty/En/RW port group and an off-block serial sink, and the FIFO never sees a read while empty.

## Interface
Parameters:
- WIDTH, 4: data word width; equals the FIFO I/O width.
- CLKS_PER_BIT, 4: clock cycles per serial bit; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clear  input  1  reset, asynchronous, active-low (0 = reset).
- run  input  1  1 = drain FIFO; 0 = finish current frame, then idle.
- fifo_empty  input  1  FIFO Empty flag.
- fifo_data  input  WIDTH  FIFO O; valid the cycle after a pop.
- fifo_en  output  1  FIFO En; 1 for exactly one cycle per pop.
- fifo_rw  output  1  FIFO RW; 0 while fifo_en=1, otherwise 1.
- tx  output  1  serial line; idle high.
- busy  output  1  1 in every state except IDLE.
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.
- last_word  output  WIDTH  word most recently captured from the FIFO.

## Operation
- Reset values: state IDLE, tx=1, fifo_en=0, fifo_rw=1, busy=0, frame_done=0, last_word=0, all counters 0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- States and transitions:
  - IDLE: if run=1 and fifo_empty=0 at the edge, go to POP. Otherwise stay in IDLE.
  - POP: one cycle with fifo_en=1 and fifo_rw=0; then go to LOAD.
  - LOAD: one cycle; at its closing edge, capture fifo_data into the shift register and into last_word; then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles; then go to DATA.
  - DATA: WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary; then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 in the last cycle. At the closing edge, if run=1 and fifo_empty=0, go to POP; otherwise go to IDLE.
- Counters:
  - The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - The bit index counts 0..WIDTH-1.
  - Each counter is wide enough for its maximum value; there is no overflow path.
- fifo_empty and run are sampled only in IDLE and at the last cycle of STOP. Changes during a frame have no effect on that frame.
- Boundary conditions:
  - Empty FIFO: no pop is ever issued; the block stays in IDLE with tx=1.
  - run falls mid-frame: the current frame completes in full, then the block goes to IDLE.
  - clear asserted mid-frame: tx=1 and all outputs return to reset values immediately (asynchronously). The word in flight is lost, and no pop occurs on the reset-release cycle.
  - Single-entry FIFO: exactly one pop; Empty rising after the pop ends draining at STOP.

## Timing
- Let P be the cycle with fifo_en=1.
- last_word updates at the end of cycle P+1.
- The start bit occupies cycles P+2 .. P+1+CLKS_PER_BIT.
- Data bit k occupies the CLKS_PER_BIT cycles starting at P+2+(k+1)·CLKS_PER_BIT.
- frame_done is asserted at cycle P+1+(WIDTH+2)·CLKS_PER_BIT.
- Frame length is (WIDTH+2)·CLKS_PER_BIT cycles, 24 with the defaults.
- Back-to-back pop spacing is (WIDTH+2)·CLKS_PER_BIT+2 cycles, 26 with the defaults.
- From run rising (FIFO non-empty, block in IDLE) to the first pop: 1 cycle.

## Test plan
- Reset values: hold clear=0 for 3 cycles, then release → tx=1, fifo_en=0, fifo_rw=1, busy=0, last_word=0; with fifo_empty=1 and run=1, fifo_en stays 0 for 50 cycles.
- Single word: FIFO holds 4'b0101, run=1 → one fifo_en pulse at P; last_word=4'b0101 at P+2; tx shows 0 | 1,0,1,0 | 1, 4 cycles each from P+2; frame_done at P+25; then IDLE.
- Back-to-back drain: write 1,2,3,4, then run=1 → exactly four pops spaced 26 cycles apart, serial words 1,2,3,4 in order, busy continuously 1 until IDLE after the 4th stop bit.
- run deasserted: drop run during the 2nd data bit of word 1 with 3 words queued → word 1 completes, no further pop, Empty stays 0.
- Reset mid-frame: pull clear low during DATA → tx=1 within the same cycle, busy=0; after release with run=1, the next pop begins a fresh frame with a full start bit.
- Parameter sweep: CLKS_PER_BIT=1 and WIDTH=8 → frame length 10 cycles, pop spacing 12 cycles, bits correct LSB-first.

Source files
------------

// File: rtl/fifo_serial_reader.sv
// Pops words from a FIFO whenever it is non-empty and sends each one as a
// framed serial stream: start bit 0, WIDTH data bits LSB-first, stop bit 1.
module fifo_serial_reader #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_en,
  output logic             fifo_rw,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [WIDTH-1:0] last_word
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      last_word <= '0;
    end else begin
      case (state)
        IDLE: if (run && !fifo_empty) state <= POP;
        POP:  state <= LOAD;
        LOAD: begin
          shreg     <= fifo_data;
          last_word <= fifo_data;
          cnt       <= '0;
          state     <= START;
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (idx == IDX_MAX) begin
              idx   <= '0;
              state <= STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // run and fifo_empty only matter here and in IDLE
          if (bit_end) begin
            cnt   <= '0;
            state <= (run && !fifo_empty) ? POP : IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset reaches them asynchronously
  always_comb begin
    fifo_en    = (state == POP);
    fifo_rw    = (state != POP);
    busy       = (state != IDLE);
    frame_done = (state == STOP) && bit_end;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader: default instance (WIDTH=4, CLKS_PER_BIT=4) and
// a WIDTH=8, CLKS_PER_BIT=1 instance, each fed by a simple FIFO model.
module tb_fifo_serial_reader;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       run_a = 1'b0, run_b = 1'b0;
  logic       empty_a, empty_b;
  logic [3:0] data_a = '0;
  logic [7:0] data_b = '0;
  logic       en_a, rw_a, tx_a, busy_a, fd_a;
  logic       en_b, rw_b, tx_b, busy_b, fd_b;
  logic [3:0] lw_a;
  logic [7:0] lw_b;

  logic [3:0] mem_a [0:63];
  logic [7:0] mem_b [0:63];
  int wa = 0, ra = 0, wb = 0, rb = 0;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_serial_reader #(.WIDTH(4), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .clear(clear), .run(run_a), .fifo_empty(empty_a), .fifo_data(data_a),
    .fifo_en(en_a), .fifo_rw(rw_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a),
    .last_word(lw_a));

  fifo_serial_reader #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .clear(clear), .run(run_b), .fifo_empty(empty_b), .fifo_data(data_b),
    .fifo_en(en_b), .fifo_rw(rw_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b),
    .last_word(lw_b));

  // FIFO models: data appears the cycle after a pop
  assign empty_a = (wa == ra);
  assign empty_b = (wb == rb);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en_a) begin data_a <= mem_a[ra % 64]; ra <= ra + 1; end
    if (en_b) begin data_b <= mem_b[rb % 64]; rb <= rb + 1; end
  end

  task automatic push(input int d, input logic [7:0] w);
    if (d == 0) begin mem_a[wa % 64] = w[3:0]; wa = wa + 1; end
    else begin mem_b[wb % 64] = w; wb = wb + 1; end
  endtask

  function automatic logic s_tx(input int d);   return d ? tx_b : tx_a;     endfunction
  function automatic logic s_en(input int d);   return d ? en_b : en_a;     endfunction
  function automatic logic s_rw(input int d);   return d ? rw_b : rw_a;     endfunction
  function automatic logic s_busy(input int d); return d ? busy_b : busy_a; endfunction
  function automatic logic s_fd(input int d);   return d ? fd_b : fd_a;     endfunction
  function automatic logic [7:0] s_lw(input int d); return d ? lw_b : {4'b0, lw_a}; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a pop, then checks the whole frame against the framing rules.
  // drop_at: cycle offset to drop run; clr_at: cycle offset to assert clear.
  task automatic check_frame(input int d, input logic [7:0] word, input int drop_at,
                             input int clr_at, output int pcyc);
    int w, c, b;
    logic found, exp_tx;
    w = d ? 8 : 4;
    c = d ? 1 : 4;
    found = 1'b0;
    pcyc = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (s_en(d)) found = 1'b1;
    end
    chk("pop_seen", {31'b0, found}, 32'd1);
    if (!found) return;
    pcyc = cyc;
    chk("pop_rw", {31'b0, s_rw(d)}, 32'd0);
    chk("pop_busy", {31'b0, s_busy(d)}, 32'd1);
    for (int t = 1; t <= (w + 2) * c + 1; t++) begin
      @(negedge clk);
      if (t == 1) exp_tx = 1'b1;
      else begin
        b = (t - 2) / c;
        if (b == 0) exp_tx = 1'b0;
        else if (b <= w) exp_tx = word[b - 1];
        else exp_tx = 1'b1;
      end
      chk($sformatf("tx_t%0d", t), {31'b0, s_tx(d)}, {31'b0, exp_tx});
      chk($sformatf("frame_done_t%0d", t), {31'b0, s_fd(d)}, {31'b0, t == (w + 2) * c + 1});
      chk($sformatf("busy_t%0d", t), {31'b0, s_busy(d)}, 32'd1);
      chk($sformatf("en_t%0d", t), {31'b0, s_en(d)}, 32'd0);
      if (t == 2) chk("last_word", {24'b0, s_lw(d)}, {24'b0, word});
      if (t == drop_at) begin
        if (d == 0) run_a = 1'b0; else run_b = 1'b0;
      end
      if (t == clr_at) begin
        clear = 1'b0;
        #1;
        chk("clr_tx", {31'b0, s_tx(d)}, 32'd1);
        chk("clr_busy", {31'b0, s_busy(d)}, 32'd0);
        chk("clr_en", {31'b0, s_en(d)}, 32'd0);
        chk("clr_rw", {31'b0, s_rw(d)}, 32'd1);
        chk("clr_fd", {31'b0, s_fd(d)}, 32'd0);
        chk("clr_lw", {24'b0, s_lw(d)}, 32'd0);
        return;
      end
    end
  endtask

  initial begin
    int p, prev, t0;
    logic [7:0] w [8];

    // Reset and empty-FIFO idle
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx_a}, 32'd1);
    chk("rst_en", {31'b0, en_a}, 32'd0);
    chk("rst_rw", {31'b0, rw_a}, 32'd1);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_fd", {31'b0, fd_a}, 32'd0);
    chk("rst_lw", {28'b0, lw_a}, 32'd0);
    chk("rst_lw_b", {24'b0, lw_b}, 32'd0);
    clear = 1'b1;
    run_a = 1'b1;
    run_b = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("empty_en", {31'b0, en_a | en_b}, 32'd0);
      chk("empty_tx", {31'b0, tx_a & tx_b}, 32'd1);
    end

    // Single word
    push(0, 8'h05);
    check_frame(0, 8'h05, -1, -1, p);
    @(negedge clk);
    chk("single_idle_busy", {31'b0, busy_a}, 32'd0);
    chk("single_idle_en", {31'b0, en_a}, 32'd0);

    // Back-to-back drain with run rising in IDLE
    run_a = 1'b0;
    for (int k = 1; k <= 4; k++) push(0, 8'(k));
    repeat (2) @(negedge clk);
    chk("norun_en", {31'b0, en_a}, 32'd0);
    run_a = 1'b1;
    t0 = cyc;
    prev = 0;
    for (int k = 1; k <= 4; k++) begin
      check_frame(0, 8'(k), -1, -1, p);
      if (k == 1) chk("run_to_pop", p - t0, 32'd1);
      else chk("spacing_a", p - prev, 32'd26);
      prev = p;
    end
    @(negedge clk);
    chk("drain_idle_busy", {31'b0, busy_a}, 32'd0);

    // run dropped during the 2nd data bit
    run_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w[k] = 8'($urandom_range(0, 15));
      push(0, w[k]);
    end
    run_a = 1'b1;
    check_frame(0, w[0], 11, -1, p);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("drop_no_pop", {31'b0, en_a}, 32'd0);
      chk("drop_busy", {31'b0, busy_a}, 32'd0);
    end
    chk("drop_not_empty", {31'b0, empty_a}, 32'd0);

    // Reset during DATA, then a fresh frame for the next word
    run_a = 1'b1;
    check_frame(0, w[1], -1, 8, p);
    repeat (2) @(negedge clk);
    chk("clr_hold_tx", {31'b0, tx_a}, 32'd1);
    clear = 1'b1;
    #1;
    chk("release_no_pop", {31'b0, en_a}, 32'd0);
    check_frame(0, w[2], -1, -1, p);
    @(negedge clk);
    chk("after_clr_idle", {31'b0, busy_a}, 32'd0);

    // Random drain
    for (int k = 0; k < 5; k++) begin
      w[k] = 8'($urandom_range(0, 15));
      push(0, w[k]);
    end
    for (int k = 0; k < 5; k++) check_frame(0, w[k], -1, -1, p);
    @(negedge clk);
    chk("rand_idle", {31'b0, busy_a}, 32'd0);

    // WIDTH=8, CLKS_PER_BIT=1
    for (int k = 0; k < 4; k++) begin
      w[k] = 8'($urandom);
      push(1, w[k]);
    end
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      check_frame(1, w[k], -1, -1, p);
      if (k > 0) chk("spacing_b", p - prev, 32'd12);
      prev = p;
    end
    @(negedge clk);
    chk("b_idle", {31'b0, busy_b}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
